// File: rtl/text_screen_renderer_if.sv
// Pixel, character-buffer and font ROM signal bundle for the text overlay renderer.
interface text_screen_renderer_if #(
    parameter int unsigned ADDR_W = 9
);
    logic [8:0]        pix_x;
    logic [8:0]        pix_y;
    logic              pix_valid;
    logic              frame_start;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              clear_req;
    logic              cursor_en;
    logic [ADDR_W-1:0] cursor_addr;
    logic              busy;
    logic [7:0]        font_ascii;
    logic [3:0]        font_row;
    logic [2:0]        font_col;
    logic              font_pixel;
    logic              ovl_pixel;
    logic              ovl_hit;
    logic              ovl_valid;

    modport master (
        output pix_x, pix_y, pix_valid, frame_start,
        output wr_en, wr_addr, wr_data, clear_req, cursor_en, cursor_addr,
        output font_pixel,
        input  busy, font_ascii, font_row, font_col,
        input  ovl_pixel, ovl_hit, ovl_valid
    );

    modport slave (
        input  pix_x, pix_y, pix_valid, frame_start,
        input  wr_en, wr_addr, wr_data, clear_req, cursor_en, cursor_addr,
        input  font_pixel,
        output busy, font_ascii, font_row, font_col,
        output ovl_pixel, ovl_hit, ovl_valid
    );
endinterface

// File: rtl/text_screen_renderer.sv
// Character-buffer text overlay: maps pixel coordinates to font ROM requests,
// returns the overlay pixel 3 cycles later, with blinking cursor and clear sequencer.
module text_screen_renderer #(
    parameter int unsigned COLS         = 32,
    parameter int unsigned ROWS         = 15,
    parameter int unsigned ADDR_W       = 9,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter logic [7:0]  CLEAR_CHAR   = 8'h20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    text_screen_renderer_if.slave  bus
);
    localparam int unsigned CELLS = COLS * ROWS;
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] clear_ptr_q;
    logic              busy_q;

    logic [7:0]        mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;

    logic [ADDR_W-1:0] cell_addr_d;
    logic              hit_d;

    logic [ADDR_W-1:0] cell_addr_q;
    logic [3:0]        row_s0_q;
    logic [2:0]        col_s0_q;
    logic              valid_s0_q;
    logic              hit_s0_q;
    logic [7:0]        rd_data_q;

    logic [7:0]        font_ascii_q;
    logic [3:0]        font_row_q;
    logic [2:0]        font_col_q;
    logic              cur_s1_q;
    logic              hit_s1_q;
    logic              valid_s1_q;

    logic              ovl_pixel_q;
    logic              ovl_hit_q;
    logic              ovl_valid_q;

    logic [BW-1:0]     blink_cnt_q;
    logic              blink_phase_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            clear_ptr_q <= '0;
            busy_q      <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.clear_req) begin
                        state_q     <= ST_CLEAR;
                        clear_ptr_q <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (32'(clear_ptr_q) == CELLS - 1) begin
                        state_q     <= ST_IDLE;
                        clear_ptr_q <= '0;
                        busy_q      <= 1'b0;
                    end else begin
                        clear_ptr_q <= clear_ptr_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // The clear sequencer owns the write port; host writes are dropped meanwhile.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.wr_addr;
        mem_wdata = bus.wr_data;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clear_ptr_q;
            mem_wdata = CLEAR_CHAR;
        end else if (bus.wr_en && (32'(bus.wr_addr) < CELLS)) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign cell_addr_d = ADDR_W'(32'(bus.pix_y[8:4]) * COLS + 32'(bus.pix_x[8:3]));
    assign hit_d       = bus.pix_valid && (32'(bus.pix_x) < COLS * 8)
                                       && (32'(bus.pix_y) < ROWS * 16);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cell_addr_q  <= '0;
            row_s0_q     <= '0;
            col_s0_q     <= '0;
            valid_s0_q   <= 1'b0;
            hit_s0_q     <= 1'b0;
            rd_data_q    <= '0;
            font_ascii_q <= '0;
            font_row_q   <= '0;
            font_col_q   <= '0;
            cur_s1_q     <= 1'b0;
            hit_s1_q     <= 1'b0;
            valid_s1_q   <= 1'b0;
            ovl_pixel_q  <= 1'b0;
            ovl_hit_q    <= 1'b0;
            ovl_valid_q  <= 1'b0;
        end else begin
            cell_addr_q  <= cell_addr_d;
            row_s0_q     <= bus.pix_y[3:0];
            col_s0_q     <= bus.pix_x[2:0];
            valid_s0_q   <= bus.pix_valid;
            hit_s0_q     <= hit_d;
            rd_data_q    <= mem_q[cell_addr_d];

            font_ascii_q <= hit_s0_q ? rd_data_q : 8'h00;
            font_row_q   <= row_s0_q;
            font_col_q   <= col_s0_q;
            cur_s1_q     <= bus.cursor_en && blink_phase_q && (cell_addr_q == bus.cursor_addr);
            hit_s1_q     <= hit_s0_q;
            valid_s1_q   <= valid_s0_q;

            ovl_pixel_q  <= hit_s1_q & (bus.font_pixel ^ cur_s1_q);
            ovl_hit_q    <= hit_s1_q;
            ovl_valid_q  <= valid_s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (bus.frame_start) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.font_ascii = font_ascii_q;
    assign bus.font_row   = font_row_q;
    assign bus.font_col   = font_col_q;
    assign bus.ovl_pixel  = ovl_pixel_q;
    assign bus.ovl_hit    = ovl_hit_q;
    assign bus.ovl_valid  = ovl_valid_q;
endmodule

// File: tb/tb_text_screen_renderer.sv
// Self-checking bench for text_screen_renderer: scoreboarded pixel scans, a vector
// table for glyph/boundary pixels, and hand sequences for clear, reset and blink.
module tb_text_screen_renderer;
    localparam int unsigned COLS  = 32;
    localparam int unsigned ROWS  = 15;
    localparam int unsigned CELLS = COLS * ROWS;

    localparam logic [7:0] GLYPH_A [16] = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                                           8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};
    localparam logic [7:0] GLYPH_B [16] = '{8'h00, 8'h00, 8'hFC, 8'h66, 8'h66, 8'h66, 8'h7C, 8'h66,
                                           8'h66, 8'h66, 8'h66, 8'hFC, 8'h00, 8'h00, 8'h00, 8'h00};

    typedef struct packed {
        logic [7:0] ascii;
        logic [3:0] row;
        logic [2:0] col;
        logic       pix;
        logic       hit;
    } exp_t;

    typedef struct {
        int   x;
        int   y;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    text_screen_renderer_if #(.ADDR_W(9)) bus ();

    text_screen_renderer #(
        .COLS(COLS), .ROWS(ROWS), .ADDR_W(9), .BLINK_FRAMES(30), .CLEAR_CHAR(8'h20)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int   total = 0;
    int   bad = 0;
    bit   sb_en = 1'b1;
    exp_t sb_q[$];

    logic [7:0] shadow [CELLS];
    int         m_cnt = 0;
    logic       m_phase = 1'b0;
    logic       m_cen = 1'b0;
    logic [8:0] m_caddr = '0;

    function automatic logic rom_bit(logic [7:0] a, logic [3:0] r, logic [2:0] c);
        logic [7:0] b;
        b = 8'h00;
        if (a == 8'h41) b = GLYPH_A[r];
        else if (a == 8'h42) b = GLYPH_B[r];
        else if (a == 8'h55) b = 8'hAA;
        return b[3'd7 - c];
    endfunction

    assign bus.font_pixel = rom_bit(bus.font_ascii, bus.font_row, bus.font_col);

    function automatic exp_t model(int x, int y);
        exp_t e;
        int   addr;
        logic cur;
        e.hit   = (x < 256) && (y < 240);
        addr    = (y / 16) * COLS + (x / 8);
        e.ascii = e.hit ? shadow[addr] : 8'h00;
        e.row   = 4'(y % 16);
        e.col   = 3'(x % 8);
        cur     = m_cen && m_phase && (9'(addr) == m_caddr);
        e.pix   = e.hit & (rom_bit(e.ascii, e.row, e.col) ^ cur);
        return e;
    endfunction

    function automatic vec_t mk(int x, int y, logic [7:0] a, int r, int c, logic p, logic h);
        vec_t v;
        v.x = x;
        v.y = y;
        v.e.ascii = a;
        v.e.row = 4'(r);
        v.e.col = 3'(c);
        v.e.pix = p;
        v.e.hit = h;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Font outputs lead the overlay by one cycle, so the previous sample is paired
    // with the overlay result being popped.
    initial begin
        exp_t e;
        logic [7:0] pa;
        logic [3:0] pr;
        logic [2:0] pc;
        pa = '0; pr = '0; pc = '0;
        forever begin
            @(posedge clk);
            #1;
            if (sb_en && bus.ovl_valid) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: got output with no expected entry");
                end else begin
                    e = sb_q.pop_front();
                    check("font_ascii", 32'(pa), 32'(e.ascii));
                    check("font_row", 32'(pr), 32'(e.row));
                    check("font_col", 32'(pc), 32'(e.col));
                    check("ovl_pixel", 32'(bus.ovl_pixel), 32'(e.pix));
                    check("ovl_hit", 32'(bus.ovl_hit), 32'(e.hit));
                end
            end
            pa = bus.font_ascii;
            pr = bus.font_row;
            pc = bus.font_col;
        end
    end

    task automatic drive_pix(int x, int y);
        @(negedge clk);
        bus.pix_x = 9'(x);
        bus.pix_y = 9'(y);
        bus.pix_valid = 1'b1;
        sb_q.push_back(model(x, y));
    endtask

    task automatic drain();
        @(negedge clk);
        bus.pix_valid = 1'b0;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        #2;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic scan_cell_row(int addr, int r);
        for (int c = 0; c < 8; c++) drive_pix((addr % COLS) * 8 + c, (addr / COLS) * 16 + r);
    endtask

    task automatic scan_cell_full(int addr);
        for (int r = 0; r < 16; r++) scan_cell_row(addr, r);
    endtask

    task automatic pulse_frames(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.frame_start = 1'b1;
            @(negedge clk);
            bus.frame_start = 1'b0;
            if (m_cnt == 29) begin
                m_cnt = 0;
                m_phase = ~m_phase;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic write_cell(int addr, logic [7:0] data);
        @(negedge clk);
        bus.wr_en = 1'b1;
        bus.wr_addr = 9'(addr);
        bus.wr_data = data;
        @(negedge clk);
        bus.wr_en = 1'b0;
        shadow[addr] = data;
    endtask

    // Counts rising edges at which busy was high just before the edge.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
        end
    endtask

    task automatic reset_model();
        m_cnt = 0;
        m_phase = 1'b0;
        for (int a = 0; a < int'(CELLS); a++) shadow[a] = 8'h20;
    endtask

    initial begin
        vec_t tbl[16];
        int n;

        tbl[0]  = mk(0,   5,   8'h41, 5,  0, 1'b1, 1'b1);
        tbl[1]  = mk(1,   5,   8'h41, 5,  1, 1'b1, 1'b1);
        tbl[2]  = mk(2,   5,   8'h41, 5,  2, 1'b0, 1'b1);
        tbl[3]  = mk(3,   5,   8'h41, 5,  3, 1'b0, 1'b1);
        tbl[4]  = mk(4,   5,   8'h41, 5,  4, 1'b0, 1'b1);
        tbl[5]  = mk(5,   5,   8'h41, 5,  5, 1'b1, 1'b1);
        tbl[6]  = mk(6,   5,   8'h41, 5,  6, 1'b1, 1'b1);
        tbl[7]  = mk(7,   5,   8'h41, 5,  7, 1'b0, 1'b1);
        tbl[8]  = mk(8,   18,  8'h42, 2,  0, 1'b1, 1'b1);
        tbl[9]  = mk(14,  18,  8'h42, 2,  6, 1'b0, 1'b1);
        tbl[10] = mk(13,  19,  8'h42, 3,  5, 1'b1, 1'b1);
        tbl[11] = mk(8,   19,  8'h42, 3,  0, 1'b0, 1'b1);
        tbl[12] = mk(256, 5,   8'h00, 5,  0, 1'b0, 1'b0);
        tbl[13] = mk(0,   240, 8'h00, 0,  0, 1'b0, 1'b0);
        tbl[14] = mk(255, 239, 8'h20, 15, 7, 1'b0, 1'b1);
        tbl[15] = mk(511, 511, 8'h00, 15, 7, 1'b0, 1'b0);

        bus.pix_x = 9'd13; bus.pix_y = 9'd19; bus.pix_valid = 1'b1;
        bus.frame_start = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.clear_req = 1'b0; bus.cursor_en = 1'b0; bus.cursor_addr = '0;
        reset_model();

        // Reset holds pipeline at zero even with a valid in-area pixel applied.
        repeat (4) @(negedge clk);
        check("rst_font_ascii", 32'(bus.font_ascii), 32'd0);
        check("rst_font_row", 32'(bus.font_row), 32'd0);
        check("rst_font_col", 32'(bus.font_col), 32'd0);
        check("rst_ovl_pixel", 32'(bus.ovl_pixel), 32'd0);
        check("rst_ovl_hit", 32'(bus.ovl_hit), 32'd0);
        check("rst_ovl_valid", 32'(bus.ovl_valid), 32'd0);
        bus.pix_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        count_busy(n);
        check("busy_after_reset", 32'(n), 32'd480);

        for (int a = 0; a < int'(CELLS); a++) scan_cell_row(a, a % 16);
        drain();

        bus.cursor_en = 1'b1; bus.cursor_addr = '0; m_cen = 1'b1; m_caddr = '0;
        scan_cell_full(0);
        drain();
        pulse_frames(30);
        scan_cell_full(0);
        scan_cell_row(1, 4);
        drain();
        pulse_frames(29);
        scan_cell_row(0, 7);
        drain();
        pulse_frames(1);
        scan_cell_full(0);
        drain();
        bus.cursor_en = 1'b0; m_cen = 1'b0;

        write_cell(0, 8'h41);
        write_cell(33, 8'h42);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.pix_x = 9'(tbl[i].x);
            bus.pix_y = 9'(tbl[i].y);
            bus.pix_valid = 1'b1;
            sb_q.push_back(tbl[i].e);
        end
        scan_cell_full(33);
        drain();

        @(negedge clk);
        bus.pix_x = 9'd0; bus.pix_y = 9'd5; bus.pix_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("invalid_ovl_valid", 32'(bus.ovl_valid), 32'd0);
        check("invalid_ovl_hit", 32'(bus.ovl_hit), 32'd0);
        check("invalid_ovl_pixel", 32'(bus.ovl_pixel), 32'd0);

        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);
        bus.clear_req = 1'b1;
        fork
            count_busy(n);
            begin
                @(negedge clk);
                bus.clear_req = 1'b1;
                bus.wr_en = 1'b1; bus.wr_addr = 9'd5; bus.wr_data = 8'h55;
                @(negedge clk);
                bus.clear_req = 1'b0; bus.wr_en = 1'b0;
                repeat (200) @(negedge clk);
                bus.clear_req = 1'b1;
                @(negedge clk);
                bus.clear_req = 1'b0;
            end
        join
        check("busy_clear_req", 32'(n), 32'd480);
        reset_model();
        scan_cell_full(5);
        scan_cell_row(0, 5);
        scan_cell_row(33, 2);
        drain();

        // Reset in the middle of a clear, with an in-area pixel streaming.
        sb_en = 1'b0;
        @(negedge clk);
        bus.clear_req = 1'b1;
        bus.pix_x = 9'd13; bus.pix_y = 9'd19; bus.pix_valid = 1'b1;
        @(negedge clk);
        bus.clear_req = 1'b0;
        repeat (100) @(negedge clk);
        check("pre_rst_font_row", 32'(bus.font_row), 32'd3);
        check("pre_rst_ovl_hit", 32'(bus.ovl_hit), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_font_row", 32'(bus.font_row), 32'd0);
        check("mid_rst_font_col", 32'(bus.font_col), 32'd0);
        check("mid_rst_ovl_hit", 32'(bus.ovl_hit), 32'd0);
        check("mid_rst_ovl_valid", 32'(bus.ovl_valid), 32'd0);
        bus.pix_valid = 1'b0;
        reset_model();
        @(posedge clk);
        #1 rst_n = 1'b1;
        count_busy(n);
        check("busy_after_mid_reset", 32'(n), 32'd480);
        repeat (4) @(negedge clk);
        sb_en = 1'b1;

        // Same-cycle read and write of cell 7 must return the prior contents.
        @(negedge clk);
        bus.pix_x = 9'd56; bus.pix_y = 9'd2; bus.pix_valid = 1'b1;
        bus.wr_en = 1'b1; bus.wr_addr = 9'd7; bus.wr_data = 8'h41;
        sb_q.push_back(model(56, 2));
        shadow[7] = 8'h41;
        drive_pix(57, 2);
        bus.wr_en = 1'b0;
        scan_cell_row(7, 5);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/text_screen_renderer.md
Name: text_screen_renderer

Overview:
- Upstream feeder of the 8x16 character font ROM in the analyzer text overlay.
- Holds a character buffer (COLS x ROWS bytes) written by the analyzer/CPU side.
- Converts incoming video pixel coordinates into font ROM requests (ascii, row, col) and returns the ROM pixel, pipeline-aligned with a valid strobe.
- Adds a blinking cursor cell and a hardware clear-screen sequencer.

Parameters:
- COLS, 32, text columns (8 px each)
- ROWS, 15, text rows (16 px each)
- ADDR_W, 9, character buffer address width; must satisfy 2^ADDR_W >= COLS*ROWS
- BLINK_FRAMES, 30, frames per cursor blink half-period
- CLEAR_CHAR, 8'h20, code written by the clear sequencer

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_x  in  9  current pixel column from video timing
- pix_y  in  9  current pixel line from video timing
- pix_valid  in  1  pix_x/pix_y are an active pixel this cycle
- frame_start  in  1  one-cycle pulse at the start of each frame
- wr_en  in  1  character buffer write strobe
- wr_addr  in  ADDR_W  write address (row*COLS + col)
- wr_data  in  8  character code
- clear_req  in  1  pulse: start a clear-screen sequence
- cursor_en  in  1  enable cursor display
- cursor_addr  in  ADDR_W  cursor cell address
- busy  out  1  clear sequence in progress
- font_ascii  out  8  to font ROM
- font_row  out  4  to font ROM
- font_col  out  3  to font ROM; 0 = leftmost pixel of the cell
- font_pixel  in  1  from font ROM, combinational on font_ascii/row/col
- ovl_pixel  out  1  final overlay pixel
- ovl_hit  out  1  pixel lies inside the text area
- ovl_valid  out  1  pix_valid delayed to align with ovl_pixel

Behaviour:
- Reset (asynchronous, active-low): all pipeline registers, font_* outputs, ovl_*, blink counter and blink phase are cleared to 0. The character buffer contents are not reset. On reset release the FSM enters CLEAR.
- FSM states:
  - IDLE, busy=0.
  - CLEAR, busy=1: clear_ptr runs 0..COLS*ROWS-1, writing CLEAR_CHAR one address per cycle, then returns to IDLE. CLEAR lasts exactly COLS*ROWS cycles (480 at defaults).
  - clear_req in IDLE -> CLEAR on the next edge. clear_req while already in CLEAR is ignored; there is no restart.
  - wr_en while busy=1 is dropped.
  - wr_addr >= COLS*ROWS is dropped.
- Stage 0 (registered, edge 1): cell_addr = (pix_y>>4)*COLS + (pix_x>>3), computed at full width and then truncated to ADDR_W. Latch pix_y[3:0], pix_x[2:0], pix_valid, and hit = pix_valid && pix_x < COLS*8 && pix_y < ROWS*16. Synchronous buffer read of cell_addr.
- Stage 1 (edge 2):
  - font_ascii = read data when hit, else 8'h00.
  - font_row and font_col are the delayed pix_y[3:0] and pix_x[2:0].
  - cur = cursor_en && blink_phase && cell_addr == cursor_addr, delayed to match.
- Stage 2 (edge 3): ovl_pixel = hit & (font_pixel ^ cur). ovl_hit and ovl_valid are the delayed values.
- Total latency from pix_* to ovl_* is exactly 3 cycles, fully pipelined at one pixel per cycle with no stalls.
- Buffer read/write collision on the same address in the same cycle: the read returns the old data (read-before-write).
- Blink: a counter increments on frame_start. When it reaches BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles. The cursor is visible while blink_phase=1.
- Outside the text area (hit=0), or when pix_valid=0: ovl_pixel=0 and ovl_hit=0. The cursor never shows there.
- The renderer keeps running during CLEAR; cells not yet cleared show stale data.

Test Plan:
- Reset release -> busy=1 for exactly 480 cycles then 0. Then scan all cells -> every font_ascii equals 8'h20 and ovl_pixel=0 everywhere (space glyph blank).
- Write 8'h41 to addr 0, scan x=0..7, y=5 -> font_ascii=8'h41, font_row=5, and ovl_pixel follows ROM row 5 of 'A' (0xC6 pattern: 1,1,0,0,0,1,1,0) with each bit 3 cycles after its pix_x.
- Write 8'h42 to addr 33, scan x=8..15, y=16..31 -> glyph 'B' appears in cell (col 1, row 1). pix_x=256 or pix_y=240 -> ovl_hit=0, ovl_pixel=0.
- Set cursor_en=1, cursor_addr=0 with the space char, pulse frame_start 30 times -> cell 0 reads all 1s. After 30 more pulses -> all 0s.
- Assert clear_req together with wr_en (addr 5, 8'h55) during CLEAR -> the write is dropped and addr 5 reads 8'h20 afterwards. A second clear_req mid-CLEAR does not extend busy beyond 480 cycles.
- Drop rst_n mid-CLEAR at ptr=100 -> outputs go to 0 immediately. After release busy lasts a full 480 cycles. Same-cycle read/write of addr 7 returns the prior value.
